// File: rtl/btn_conditioner.sv
// Push-button conditioner: synchronizer, debounce FSM,
// press/release pulses and auto-repeat move-enable pulses.
module btn_conditioner #(
  parameter int DEB_CYCLES    = 1000000,
  parameter int REPEAT_DELAY  = 50000000,
  parameter int REPEAT_PERIOD = 10000000,
  parameter int CNT_W         = 26
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_in,
  output logic       db_level,
  output logic       press_pulse,
  output logic       release_pulse,
  output logic       repeat_pulse,
  output logic [2:0] state_o
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    DEB_PRESS = 3'd1,
    HELD      = 3'd2,
    REPEAT    = 3'd3,
    DEB_REL   = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] DEB_TC = CNT_W'(DEB_CYCLES - 1);
  localparam logic [CNT_W-1:0] DLY_TC = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] PER_TC = CNT_W'(REPEAT_PERIOD - 1);

  logic             meta_q, sync_q;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             db_q, db_d;
  logic             press_q, press_d;
  logic             rel_q, rel_d;
  logic             rep_q, rep_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q  <= 1'b0;
      sync_q  <= 1'b0;
      state_q <= IDLE;
      cnt_q   <= '0;
      db_q    <= 1'b0;
      press_q <= 1'b0;
      rel_q   <= 1'b0;
      rep_q   <= 1'b0;
    end else begin
      meta_q  <= btn_in;
      sync_q  <= meta_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      db_q    <= db_d;
      press_q <= press_d;
      rel_q   <= rel_d;
      rep_q   <= rep_d;
    end
  end

  // A low sample is tested first so release beats a repeat terminal count.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    press_d = 1'b0;
    rel_d   = 1'b0;
    rep_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (sync_q) state_d = DEB_PRESS;
      end
      DEB_PRESS: begin
        if (!sync_q) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == DEB_TC) begin
          state_d = HELD;
          cnt_d   = '0;
          press_d = 1'b1;
          rep_d   = 1'b1;
        end
      end
      HELD: begin
        if (!sync_q) begin
          state_d = DEB_REL;
          cnt_d   = '0;
        end else if (cnt_q == DLY_TC) begin
          state_d = REPEAT;
          cnt_d   = '0;
          rep_d   = 1'b1;
        end
      end
      REPEAT: begin
        if (!sync_q) begin
          state_d = DEB_REL;
          cnt_d   = '0;
        end else if (cnt_q == PER_TC) begin
          cnt_d = '0;
          rep_d = 1'b1;
        end
      end
      DEB_REL: begin
        if (sync_q) begin
          state_d = HELD;
          cnt_d   = '0;
        end else if (cnt_q == DEB_TC) begin
          state_d = IDLE;
          cnt_d   = '0;
          rel_d   = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    db_d = (state_d == HELD) || (state_d == REPEAT)
        || (state_d == DEB_REL);
  end

  assign db_level      = db_q;
  assign press_pulse   = press_q;
  assign release_pulse = rel_q;
  assign repeat_pulse  = rep_q;
  assign state_o       = state_q;

endmodule
